// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, transmitter FSM states and the baud divisor helper.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
`endif

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through head and registered occupancy.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: input FIFO feeding a start/data/[parity]/stop serialiser, frames back-to-back.
// Define UART_TX_PARITY_EN to build the parity state and generator.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 50000000,
  parameter int      BAUD_RATE  = 115200,
  parameter int      DATA_BITS  = 8,
  parameter int      STOP_BITS  = 1,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = 4;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 load;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 bit_end;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (load),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_ready = !fifo_full;
  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);
  assign bit_end = (baud_q == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ACTIVE = (PARITY != PAR_NONE);
  logic par_q, par_d;
`else
  logic unused_parity;
  assign unused_parity = (PARITY != PAR_NONE);
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        load   = !fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            state_d = ST_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (PAR_ACTIVE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      state_d = ST_START;
      shift_d = head;
      baud_d  = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (PARITY == PAR_ODD) ? ~(^head) : ^head;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: three instances (8-bit even, 7-bit/2-stop, 8-bit odd), BAUD_DIV = 10.
// Parity expectations apply only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_stream;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LEN_P = PAR_EN ? 110 : 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] vld = '0;
  logic [2:0] rdy_w, tx_w, busy_w;
  logic [7:0] sd_a = '0, sd_c = '0;
  logic [6:0] sd_b = '0;
  logic [2:0] lvl_a;
  logic [4:0] lvl_b, lvl_c;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
                   .PARITY(PAR_EVEN), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .s_valid(vld[0]), .s_ready(rdy_w[0]), .s_data(sd_a),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_level(lvl_a));

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2),
                   .PARITY(PAR_NONE), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .s_valid(vld[1]), .s_ready(rdy_w[1]), .s_data(sd_b),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_level(lvl_b));

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
                   .PARITY(PAR_ODD), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .reset(reset), .s_valid(vld[2]), .s_ready(rdy_w[2]), .s_data(sd_c),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_level(lvl_c));

  typedef struct {
    logic [8:0] data;
    logic       par;
    bit         b2b;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   nbits [3] = '{8, 7, 8};
  int   nstop [3] = '{1, 2, 1};
  bit   has_par [3] = '{PAR_EN, 1'b0, PAR_EN};
  int   run_cnt [3] = '{0, 0, 0};
  int   last_run [3] = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int level_of(input int k);
    case (k)
      0:       return int'(lvl_a);
      1:       return int'(lvl_b);
      default: return int'(lvl_c);
    endcase
  endfunction

  function automatic void sb_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t sb_pop(input int k);
    exp_t e;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Length of the most recent contiguous tx_busy run per instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        run_cnt[k] <= 0;
      end else if (busy_w[k]) begin
        run_cnt[k] <= run_cnt[k] + 1;
      end else if (run_cnt[k] != 0) begin
        last_run[k] <= run_cnt[k];
        run_cnt[k]  <= 0;
      end
    end
  end

  task automatic drive(input int k, input logic v, input logic [8:0] d);
    vld[k] = v;
    case (k)
      0:       sd_a = d[7:0];
      1:       sd_b = d[6:0];
      default: sd_c = d[7:0];
    endcase
  endtask

  task automatic push(input int k, input logic [8:0] d, input logic par, input bit b2b);
    exp_t e;
    @(negedge clk);
    drive(k, 1'b1, d);
    check($sformatf("ready_at_push_u%0d", k), int'(rdy_w[k]), 1);
    @(posedge clk);
    e.data = d;
    e.par  = par;
    e.b2b  = b2b;
    sb_push(k, e);
  endtask

  task automatic release_valid(input int k);
    @(negedge clk);
    drive(k, 1'b0, 9'h000);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sb_size(k) != 0 || busy_w[k]) && t < 3000);
    if (t >= 3000) check($sformatf("idle_timeout_u%0d", k), 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Decodes every frame cycle by cycle and checks it against the scoreboard head.
  task automatic monitor(input int k);
    exp_t       e;
    bit         have_start;
    bit         b2b_seen;
    bit         shape_ok;
    bit         aborted;
    logic [8:0] got;
    logic       got_par;
    logic       exp_bit;
    int         nb;
    have_start = 1'b0;
    forever begin
      b2b_seen = have_start;
      if (!have_start) begin
        do @(negedge clk); while (reset || tx_w[k] !== 1'b0);
      end
      have_start = 1'b0;
      if (sb_size(k) == 0) begin
        check($sformatf("unexpected_frame_u%0d", k), 1, 0);
        while (busy_w[k] && !reset) @(negedge clk);
        continue;
      end
      e        = sb_pop(k);
      shape_ok = 1'b1;
      aborted  = 1'b0;
      got      = '0;
      got_par  = 1'b0;
      if (e.b2b) check($sformatf("back_to_back_u%0d", k), int'(b2b_seen), 1);
      nb = 1 + nbits[k] + (has_par[k] ? 1 : 0) + nstop[k];
      for (int b = 0; b < nb && !aborted; b++) begin
        if (b == 0)                                exp_bit = 1'b0;
        else if (b <= nbits[k])                    exp_bit = e.data[b-1];
        else if (has_par[k] && b == nbits[k] + 1)  exp_bit = e.par;
        else                                       exp_bit = 1'b1;
        for (int c = 0; c < 10 && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
          end else begin
            if (c == 5 && b >= 1 && b <= nbits[k]) got[b-1] = tx_w[k];
            if (c == 5 && has_par[k] && b == nbits[k] + 1) got_par = tx_w[k];
            if (tx_w[k] !== exp_bit || busy_w[k] !== 1'b1) shape_ok = 1'b0;
          end
        end
      end
      if (aborted) continue;
      check($sformatf("data_u%0d", k), int'(got), int'(e.data));
      if (has_par[k]) check($sformatf("parity_u%0d", k), int'(got_par), int'(e.par));
      check($sformatf("frame_shape_u%0d", k), int'(shape_ok), 1);
      @(negedge clk);
      if (reset) continue;
      if (tx_w[k] == 1'b0) have_start = 1'b1;
      else check($sformatf("busy_after_frame_u%0d", k), int'(busy_w[k]), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_rdy [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int   exp_lvl [8] = '{0, 1, 1, 2, 3, 4, 4, 4};
    logic fifo_par [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   acc;
    int   prev;
    int   t;
    int   busy_seen;
    int   low_seen;
    exp_t e;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_tx", int'(tx_w[0]), 1);
    check("reset_busy", int'(busy_w[0]), 0);
    check("reset_ready", int'(rdy_w[0]), 1);
    check("reset_level", level_of(0), 0);
    check("reset_tx_u1", int'(tx_w[1]), 1);

    // Single frame 0x55.
    push(0, 9'h055, 1'b0, 1'b0);
    release_valid(0);
    wait_idle(0);
    check("single_busy_len", last_run[0], LEN_P);

    // Three words on consecutive cycles, sent without gaps.
    push(0, 9'h0A5, 1'b0, 1'b0);
    push(0, 9'h000, 1'b0, 1'b1);
    push(0, 9'h0FF, 1'b0, 1'b1);
    release_valid(0);
    wait_idle(0);
    check("b2b_busy_len", last_run[0], 3 * LEN_P);

    // 0x07 even parity on u_a, odd parity on u_c.
    push(0, 9'h007, 1'b1, 1'b0);
    release_valid(0);
    wait_idle(0);
    check("even_busy_len", last_run[0], LEN_P);
    push(2, 9'h007, 1'b0, 1'b0);
    release_valid(2);
    wait_idle(2);
    check("odd_busy_len", last_run[2], LEN_P);

    // Seven data bits, two stop bits.
    push(1, 9'h07F, 1'b0, 1'b0);
    release_valid(1);
    wait_idle(1);
    check("d7s2_busy_len", last_run[1], 100);

    // FIFO fill on the depth-4 instance with s_valid held for 8 cycles.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 9'(i + 1));
      check($sformatf("fill_level_%0d", i), level_of(0), exp_lvl[i]);
      check($sformatf("fill_ready_%0d", i), int'(rdy_w[0]), exp_rdy[i]);
      acc += int'(rdy_w[0]);
      @(posedge clk);
      if (exp_rdy[i] == 1) begin
        e.data = 9'(i + 1);
        e.par  = fifo_par[i];
        e.b2b  = (i > 0);
        sb_push(0, e);
      end
    end
    release_valid(0);
    check("fill_accepted", acc, 5);
    prev = level_of(0);
    for (int j = 1; j <= 4; j++) begin
      t = 0;
      while (level_of(0) == prev && t < 200) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("drain_level_%0d", j), level_of(0), 4 - j);
      check($sformatf("drain_at_start_%0d", j), int'(tx_w[0]), 0);
      prev = level_of(0);
    end
    wait_idle(0);
    check("fill_busy_len", last_run[0], 5 * LEN_P);

    // Reset during data bit 3 with two words still queued.
    push(0, 9'h011, 1'b0, 1'b0);
    push(0, 9'h022, 1'b0, 1'b1);
    push(0, 9'h033, 1'b0, 1'b1);
    release_valid(0);
    repeat (43) @(negedge clk);
    check("pre_reset_level", level_of(0), 2);
    check("pre_reset_busy", int'(busy_w[0]), 1);
    #2;
    reset = 1'b1;
    q0.delete();
    #1;
    check("async_reset_tx", int'(tx_w[0]), 1);
    check("async_reset_busy", int'(busy_w[0]), 0);
    check("async_reset_level", level_of(0), 0);
    check("async_reset_ready", int'(rdy_w[0]), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    low_seen  = 0;
    repeat (300) begin
      @(negedge clk);
      busy_seen += int'(busy_w[0]);
      low_seen  += int'(!tx_w[0]);
    end
    check("post_reset_busy_cycles", busy_seen, 0);
    check("post_reset_tx_low_cycles", low_seen, 0);
    check("post_reset_level", level_of(0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
